core_bus_router: RTL and testbench
==================================

Name: core_bus_router

Overview:
- Sits between bridge_rx and bridge_tx and shares that single host request/response path among N_CORES debug cores (logic analyzers, IO cores, and so on).
- Decodes the upper address bits to select a core and forwards the request with a region-local address.
- Sequences one transaction at a time, waits for the selected core's read response, and returns one read response to bridge_tx.
- Supplies an error word when a read times out or addresses no core.

Parameters:
- N_CORES, 4, number of downstream cores (1..8).
- REGION_LOG2, 12, log2 of words per core region; core index = addr_i >> REGION_LOG2.
- TIMEOUT, 255, cycles to wait for a read response before erroring (1..65535).
- ERR_RDATA, 16'hFFFF, rdata returned on timeout or unmapped read.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- addr_i  in  16  request address from bridge_rx.
- wdata_i  in  16  request write data.
- rw_i  in  1  1=write, 0=read.
- valid_i  in  1  one-cycle request strobe.
- busy_o  out  1  high whenever state != IDLE.
- core_addr_o  out  16  region-local address (addr_i with index bits zeroed).
- core_wdata_o  out  16  write data to cores.
- core_rw_o  out  1  rw to cores.
- core_valid_o  out  N_CORES  one-hot request strobe.
- core_rdata_i  in  16*N_CORES  core read data; core k occupies bits [16k+15:16k].
- core_rvalid_i  in  N_CORES  per-core read-response strobe.
- rdata_o  out  16  response data to bridge_tx.
- rw_o  out  1  always 0 when valid_o=1.
- valid_o  out  1  one-cycle response strobe.

Behaviour:
- Clocking and reset:
  - One clock domain; reset is synchronous, active-low.
  - On rst_n=0 at a clk edge: state=IDLE, all outputs 0, timer 0, latched request cleared.
  - Reset mid-transaction abandons it; no response is emitted.
- All outputs are registered.
- States are IDLE, ISSUE, WAIT_RD, RESP.
- IDLE:
  - On valid_i=1, latch addr/wdata/rw, compute sel and mapped = (index < N_CORES), then go to ISSUE.
- ISSUE (exactly 1 cycle):
  - If mapped: core_valid_o[sel]=1, other bits 0, with core_addr_o/core_wdata_o/core_rw_o valid in the same cycle.
  - Mapped write: go to IDLE; writes produce no response.
  - Mapped read: load timer=TIMEOUT and go to WAIT_RD.
  - Unmapped read: go to RESP with rdata=ERR_RDATA; no core strobe.
  - Unmapped write: silently dropped, go to IDLE.
- WAIT_RD:
  - If core_rvalid_i[sel]=1, capture that core's rdata slice and go to RESP.
  - Else if timer==0, rdata=ERR_RDATA and go to RESP.
  - Else timer decrements.
  - rvalid from non-selected cores is ignored.
  - If rvalid and timer==0 occur together, real data wins.
- RESP:
  - valid_o=1, rw_o=0, rdata_o held; go to IDLE the next cycle.
  - rdata_o holds its value until the next response.
- Latency:
  - Mapped write: valid_i to core_valid_o is 1 cycle.
  - Read: valid_o follows core_rvalid_i by 1 cycle.
  - Timeout: valid_o arrives TIMEOUT+3 cycles after valid_i.
- valid_i while busy_o=1: the request is dropped, with no effect on the current transaction.
- Back-to-back: valid_i in the same cycle the router enters IDLE is accepted.

Optional Feature:
- Macro: CORE_BUS_ROUTER_STATS_EN.
- When defined:
  - Adds outputs drop_count_o[15:0] (requests dropped while busy) and timeout_count_o[15:0] (read timeouts).
  - Both counters saturate at 16'hFFFF and clear on reset.
  - Unmapped accesses do not count toward either counter.
- When undefined: these ports and the counter logic are absent; all other behaviour is identical.

Decomposition:
- Package core_bus_router_pkg holds:
  - State enum {IDLE, ISSUE, WAIT_RD, RESP} (2-bit).
  - ADDR_W=16, DATA_W=16.
  - Default ERR_RDATA constant.
- One sub-module, core_bus_router_decode, is natural: combinational addr → {sel, mapped, local_addr}, parameterized by N_CORES and REGION_LOG2.
- Timer and stats counters stay inline.

Test Plan:
- Mapped read: read 16'h1004 (core 1, local 16'h0004); core 1 asserts rvalid with 16'hA5A5 three cycles after its strobe → core_valid_o=4'b0010, core_addr_o=16'h0004; valid_o=1 with rdata_o=16'hA5A5, rw_o=0, one cycle after that rvalid.
- Mapped write: write 16'h3010 with data 16'h1234 → core_valid_o=4'b1000 for one cycle with core_wdata_o=16'h1234, core_rw_o=1; valid_o never asserts; busy_o low 2 cycles after valid_i.
- Timeout: read 16'h0000 with core 0 never responding, TIMEOUT=5 → valid_o at cycle 8 after valid_i with rdata_o=16'hFFFF; timeout_count_o=1 with the macro defined.
- Unmapped accesses, N_CORES=3: read 16'h3000 → no core_valid_o bit set, valid_o 2 cycles after valid_i with rdata_o=16'hFFFF; write 16'h3000 → no strobe and no response.
- Drop while busy and wrong-core rvalid: second valid_i during WAIT_RD, with core 2 pulsing rvalid while core 0 is selected → second request ignored, first response still comes from core 0, drop_count_o=1.
- Reset mid-WAIT_RD: rst_n=0 for one edge, then a late core rvalid arrives → no valid_o, state IDLE, all outputs 0; the next read completes normally.

Source files
------------

// File: rtl/core_bus_router_pkg.sv
// Shared types and constants for the core bus router.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//   state_e           - router FSM state (2-bit)
//   ADDR_W / DATA_W   - host and core bus widths
//   SEL_W             - core index width (up to 8 cores)
//   ERR_RDATA_DEFAULT - rdata returned when a read times out or hits no core
package core_bus_router_pkg;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 16;
    localparam int SEL_W   = 3;
    localparam int TIMER_W = 16;

    localparam logic [DATA_W-1:0] ERR_RDATA_DEFAULT = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        RESP    = 2'd3
    } state_e;

endpackage

// File: rtl/core_bus_router_if.sv
// Host request/response path plus fan-out bus to the debug cores.
// Latency: n/a (wires only).
// Backpressure: none; the router drops host requests while busy_o is high.
//   slave  - router side: takes host request and core responses, drives the rest
//   master - environment side (bridge + cores): the mirror image
interface core_bus_router_if #(
    parameter int N_CORES = 4
);
    import core_bus_router_pkg::*;

    // host request from bridge_rx
    logic [ADDR_W-1:0]         addr_i;
    logic [DATA_W-1:0]         wdata_i;
    logic                      rw_i;
    logic                      valid_i;
    logic                      busy_o;
    // fan-out to cores
    logic [ADDR_W-1:0]         core_addr_o;
    logic [DATA_W-1:0]         core_wdata_o;
    logic                      core_rw_o;
    logic [N_CORES-1:0]        core_valid_o;
    logic [DATA_W*N_CORES-1:0] core_rdata_i;
    logic [N_CORES-1:0]        core_rvalid_i;
    // response to bridge_tx
    logic [DATA_W-1:0]         rdata_o;
    logic                      rw_o;
    logic                      valid_o;

    modport slave (
        input  addr_i, wdata_i, rw_i, valid_i, core_rdata_i, core_rvalid_i,
        output busy_o, core_addr_o, core_wdata_o, core_rw_o, core_valid_o,
               rdata_o, rw_o, valid_o
    );

    modport master (
        output addr_i, wdata_i, rw_i, valid_i, core_rdata_i, core_rvalid_i,
        input  busy_o, core_addr_o, core_wdata_o, core_rw_o, core_valid_o,
               rdata_o, rw_o, valid_o
    );

endinterface

// File: rtl/core_bus_router_decode.sv
// Address decode: splits a host address into core index and region-local offset.
// Latency: combinational.
// Backpressure: n/a.
//   addr_i       - host address
//   sel_o        - core index (low SEL_W bits of addr_i >> REGION_LOG2)
//   mapped_o     - full index is below N_CORES
//   local_addr_o - addr_i with the index bits cleared
module core_bus_router_decode
    import core_bus_router_pkg::*;
#(
    parameter int N_CORES     = 4,
    parameter int REGION_LOG2 = 12
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic [SEL_W-1:0]  sel_o,
    output logic              mapped_o,
    output logic [ADDR_W-1:0] local_addr_o
);

    localparam logic [ADDR_W-1:0] N_CORES_A  = ADDR_W'(N_CORES);
    localparam logic [ADDR_W-1:0] LOCAL_MASK = ~({ADDR_W{1'b1}} << REGION_LOG2);

    logic [ADDR_W-1:0] idx;

    always_comb begin
        idx          = addr_i >> REGION_LOG2;
        sel_o        = idx[SEL_W-1:0];
        // compare the whole index so aliases above the core count stay unmapped
        mapped_o     = (idx < N_CORES_A);
        local_addr_o = addr_i & LOCAL_MASK;
    end

endmodule

// File: rtl/core_bus_router.sv
// Shares one host request/response path among N_CORES debug cores, one transaction at a time.
// Latency: strobe 1 cycle after valid_i; response 1 cycle after core rvalid, or TIMEOUT+3 after valid_i.
// Backpressure: none; valid_i while busy_o=1 is dropped (counted when CORE_BUS_ROUTER_STATS_EN is defined).
//   clk, rst_n      - clock and synchronous active-low reset
//   bus (slave)     - host request/response and core fan-out, see core_bus_router_if
//   drop_count_o    - saturating count of requests dropped while busy   (CORE_BUS_ROUTER_STATS_EN)
//   timeout_count_o - saturating count of read timeouts                 (CORE_BUS_ROUTER_STATS_EN)
module core_bus_router
    import core_bus_router_pkg::*;
#(
    parameter int                N_CORES     = 4,
    parameter int                REGION_LOG2 = 12,
    parameter int                TIMEOUT     = 255,
    parameter logic [DATA_W-1:0] ERR_RDATA   = ERR_RDATA_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    core_bus_router_if.slave bus
`ifdef CORE_BUS_ROUTER_STATS_EN
    ,
    output logic [15:0]      drop_count_o,
    output logic [15:0]      timeout_count_o
`endif
);

    state_e               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [ADDR_W-1:0]    req_addr_q, req_addr_d;
    logic [DATA_W-1:0]    req_wdata_q, req_wdata_d;
    logic                 req_rw_q, req_rw_d;
    logic [SEL_W-1:0]     req_sel_q, req_sel_d;
    logic                 req_mapped_q, req_mapped_d;
    logic [N_CORES-1:0]   core_valid_q, core_valid_d;
    logic                 busy_q, busy_d;
    logic                 valid_q, valid_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;

    logic [SEL_W-1:0]     dec_sel;
    logic                 dec_mapped;
    logic [ADDR_W-1:0]    dec_local;
    logic                 sel_rvalid;
    logic [DATA_W-1:0]    sel_rdata;
    logic [N_CORES-1:0]   dec_onehot;

    core_bus_router_decode #(
        .N_CORES    (N_CORES),
        .REGION_LOG2(REGION_LOG2)
    ) u_decode (
        .addr_i      (bus.addr_i),
        .sel_o       (dec_sel),
        .mapped_o    (dec_mapped),
        .local_addr_o(dec_local)
    );

    // Response mux for the latched core and strobe pattern for the incoming request.
    always_comb begin
        sel_rvalid = 1'b0;
        sel_rdata  = '0;
        dec_onehot = '0;
        for (int k = 0; k < N_CORES; k++) begin
            if (req_sel_q == SEL_W'(k)) begin
                sel_rvalid = bus.core_rvalid_i[k];
                sel_rdata  = bus.core_rdata_i[DATA_W*k +: DATA_W];
            end
            dec_onehot[k] = (dec_sel == SEL_W'(k));
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.valid_i) state_d = ISSUE;
            ISSUE:   if (req_rw_q)    state_d = IDLE;
                     else             state_d = req_mapped_q ? WAIT_RD : RESP;
            // a response in the last timer cycle still beats the timeout
            WAIT_RD: if (sel_rvalid || timer_q == '0) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath logic; every output is the flop of a value computed here.
    always_comb begin
        timer_d      = timer_q;
        req_addr_d   = req_addr_q;
        req_wdata_d  = req_wdata_q;
        req_rw_d     = req_rw_q;
        req_sel_d    = req_sel_q;
        req_mapped_d = req_mapped_q;
        core_valid_d = '0;
        rdata_d      = rdata_q;

        case (state_q)
            IDLE: begin
                if (bus.valid_i) begin
                    req_addr_d   = dec_local;
                    req_wdata_d  = bus.wdata_i;
                    req_rw_d     = bus.rw_i;
                    req_sel_d    = dec_sel;
                    req_mapped_d = dec_mapped;
                    // strobe lands in the ISSUE cycle because it is registered here
                    if (dec_mapped) core_valid_d = dec_onehot;
                end
            end
            ISSUE: begin
                if (!req_rw_q) begin
                    if (req_mapped_q) timer_d = TIMER_W'(TIMEOUT);
                    else              rdata_d = ERR_RDATA;
                end
            end
            WAIT_RD: begin
                if (sel_rvalid)            rdata_d = sel_rdata;
                else if (timer_q == '0)    rdata_d = ERR_RDATA;
                else                       timer_d = timer_q - 1'b1;
            end
            default: ;
        endcase

        busy_d  = (state_d != IDLE);
        valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
            req_rw_q     <= 1'b0;
            req_sel_q    <= '0;
            req_mapped_q <= 1'b0;
            core_valid_q <= '0;
            busy_q       <= 1'b0;
            valid_q      <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            req_addr_q   <= req_addr_d;
            req_wdata_q  <= req_wdata_d;
            req_rw_q     <= req_rw_d;
            req_sel_q    <= req_sel_d;
            req_mapped_q <= req_mapped_d;
            core_valid_q <= core_valid_d;
            busy_q       <= busy_d;
            valid_q      <= valid_d;
            rdata_q      <= rdata_d;
        end
    end

    assign bus.busy_o       = busy_q;
    assign bus.core_addr_o  = req_addr_q;
    assign bus.core_wdata_o = req_wdata_q;
    assign bus.core_rw_o    = req_rw_q;
    assign bus.core_valid_o = core_valid_q;
    assign bus.rdata_o      = rdata_q;
    assign bus.rw_o         = 1'b0;   // only read responses are ever returned
    assign bus.valid_o      = valid_q;

`ifdef CORE_BUS_ROUTER_STATS_EN
    logic [15:0] drop_count_q, drop_count_d;
    logic [15:0] timeout_count_q, timeout_count_d;

    always_comb begin
        drop_count_d    = drop_count_q;
        timeout_count_d = timeout_count_q;
        if (bus.valid_i && state_q != IDLE && drop_count_q != 16'hFFFF)
            drop_count_d = drop_count_q + 16'd1;
        // only mapped reads reach WAIT_RD, so unmapped errors never count here
        if (state_q == WAIT_RD && !sel_rvalid && timer_q == '0 && timeout_count_q != 16'hFFFF)
            timeout_count_d = timeout_count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_count_q    <= '0;
            timeout_count_q <= '0;
        end else begin
            drop_count_q    <= drop_count_d;
            timeout_count_q <= timeout_count_d;
        end
    end

    assign drop_count_o    = drop_count_q;
    assign timeout_count_o = timeout_count_q;
`endif

endmodule

// File: tb/tb_core_bus_router.sv
// Self-checking bench for core_bus_router (N_CORES=3, REGION_LOG2=12, TIMEOUT=5).
// Each transaction's expected strobe, response cycle/data and busy span come from the
// documented latency rules; responding cores and noise on other cores are randomized.
module tb_core_bus_router;

    localparam int          NC  = 3;
    localparam int          TO  = 5;
    localparam logic [15:0] ERR = 16'hFFFF;
    localparam int          WIN = 14;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    core_bus_router_if #(.N_CORES(NC)) bus_if ();

`ifdef CORE_BUS_ROUTER_STATS_EN
    logic [15:0] drop_count;
    logic [15:0] timeout_count;
`endif

    core_bus_router #(
        .N_CORES    (NC),
        .REGION_LOG2(12),
        .TIMEOUT    (TO),
        .ERR_RDATA  (ERR)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
`ifdef CORE_BUS_ROUTER_STATS_EN
        ,
        .drop_count_o   (drop_count),
        .timeout_count_o(timeout_count)
`endif
    );

    int          tests = 0;
    int          fails = 0;
    logic [15:0] last_rdata;
    int          exp_drops;
    int          exp_tos;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string nm);
        chk({nm, ".busy"},       32'(bus_if.busy_o),       32'd0);
        chk({nm, ".core_addr"},  32'(bus_if.core_addr_o),  32'd0);
        chk({nm, ".core_wdata"}, 32'(bus_if.core_wdata_o), 32'd0);
        chk({nm, ".core_rw"},    32'(bus_if.core_rw_o),    32'd0);
        chk({nm, ".core_valid"}, 32'(bus_if.core_valid_o), 32'd0);
        chk({nm, ".rdata"},      32'(bus_if.rdata_o),      32'd0);
        chk({nm, ".rw_o"},       32'(bus_if.rw_o),         32'd0);
        chk({nm, ".valid"},      32'(bus_if.valid_o),      32'd0);
    endtask

    // Random data on every core; random rvalid on cores other than the one being
    // waited on; the responding core pulses rvalid with data r in cycle rvc.
    task automatic drive_cores(input int n, input int sel, input bit protect, input int rvc,
                               input logic [15:0] r);
        logic [NC-1:0] rv;
        for (int k = 0; k < NC; k++) bus_if.core_rdata_i[16*k +: 16] = 16'($urandom);
        rv = NC'($urandom);
        if (protect) rv[sel] = 1'b0;
        if (n == rvc) begin
            rv[sel] = 1'b1;
            bus_if.core_rdata_i[16*sel +: 16] = r;
        end
        bus_if.core_rvalid_i = rv;
    endtask

    // One host request issued in cycle 0; d = cycles from strobe to the core's rvalid;
    // dropk = cycle of an extra request while busy (0 = none); b2b = next request in the
    // first idle cycle.
    task automatic txn(input logic [15:0] a, input logic [15:0] wd, input logic rw, input int d,
                       input int dropk_in, input bit b2b, input logic [15:0] r, input string nm);
        int          idx, sel, exp_resp, lastbusy, w, rvc, dropk;
        bit          mapped;
        logic [15:0] exp_rd;
        int          n_strb, strb_cyc, n_val, val_cyc, n_busy, lb_obs;
        logic [NC-1:0] strb_val;
        logic [15:0] strb_addr, strb_wd, val_rd;
        logic        strb_rw, val_rw;

        idx    = int'(a >> 12);
        mapped = (idx < NC);
        sel    = mapped ? idx : 0;
        exp_resp = -1;
        exp_rd   = last_rdata;
        rvc      = -1;
        if (mapped && !rw) begin
            rvc = 1 + d;
            if (d <= TO + 1) begin
                exp_resp = 2 + d;
                exp_rd   = r;
            end else begin
                exp_resp = TO + 3;
                exp_rd   = ERR;
                exp_tos++;
            end
        end else if (!mapped && !rw) begin
            exp_resp = 2;
            exp_rd   = ERR;
        end
        lastbusy = (exp_resp > 0) ? exp_resp : 1;
        w        = b2b ? lastbusy + 1 : WIN;
        dropk    = (dropk_in > lastbusy) ? lastbusy : dropk_in;
        if (dropk > 0) exp_drops++;

        n_strb = 0; strb_cyc = -1; n_val = 0; val_cyc = -1; n_busy = 0; lb_obs = 0;
        strb_val = '0; strb_addr = '0; strb_wd = '0; strb_rw = 1'b0; val_rd = '0; val_rw = 1'b0;

        bus_if.addr_i  = a;
        bus_if.wdata_i = wd;
        bus_if.rw_i    = rw;
        bus_if.valid_i = 1'b1;
        drive_cores(0, sel, mapped, rvc, r);

        for (int n = 1; n <= w; n++) begin
            step();
            if (bus_if.core_valid_o != '0) begin
                n_strb++;
                if (n_strb == 1) begin
                    strb_cyc  = n;
                    strb_val  = bus_if.core_valid_o;
                    strb_addr = bus_if.core_addr_o;
                    strb_wd   = bus_if.core_wdata_o;
                    strb_rw   = bus_if.core_rw_o;
                end
            end
            if (bus_if.valid_o) begin
                n_val++;
                if (n_val == 1) begin
                    val_cyc = n;
                    val_rd  = bus_if.rdata_o;
                    val_rw  = bus_if.rw_o;
                end
            end
            if (bus_if.busy_o) begin
                n_busy++;
                lb_obs = n;
            end
            if (n < w) begin
                bus_if.valid_i = (n == dropk);
                if (n == dropk) begin
                    bus_if.addr_i  = {4'($urandom_range(0, NC - 1)), 12'($urandom)};
                    bus_if.wdata_i = 16'($urandom);
                    bus_if.rw_i    = 1'($urandom);
                end
                drive_cores(n, sel, mapped, rvc, r);
            end else begin
                bus_if.valid_i       = 1'b0;
                bus_if.core_rvalid_i = '0;
            end
        end

        chk({nm, ".strobes"}, 32'(n_strb), mapped ? 32'd1 : 32'd0);
        if (mapped) begin
            chk({nm, ".strobe_cycle"}, 32'(strb_cyc),  32'd1);
            chk({nm, ".strobe_bits"},  32'(strb_val),  32'(1 << sel));
            chk({nm, ".core_addr"},    32'(strb_addr), 32'(a & 16'h0FFF));
            chk({nm, ".core_wdata"},   32'(strb_wd),   32'(wd));
            chk({nm, ".core_rw"},      32'(strb_rw),   32'(rw));
        end
        chk({nm, ".responses"}, 32'(n_val), (exp_resp > 0) ? 32'd1 : 32'd0);
        if (exp_resp > 0) begin
            chk({nm, ".resp_cycle"}, 32'(val_cyc), 32'(exp_resp));
            chk({nm, ".resp_rdata"}, 32'(val_rd),  32'(exp_rd));
            chk({nm, ".resp_rw"},    32'(val_rw),  32'd0);
            last_rdata = exp_rd;
        end
        chk({nm, ".busy_cycles"}, 32'(n_busy), 32'(lastbusy));
        chk({nm, ".busy_last"},   32'(lb_obs), 32'(lastbusy));
        chk({nm, ".rdata_hold"},  32'(bus_if.rdata_o), 32'(last_rdata));
    endtask

    initial begin
        int          n_val, n_busy, n_strb;
        int          idx;
        logic [15:0] a;

        bus_if.addr_i        = '0;
        bus_if.wdata_i       = '0;
        bus_if.rw_i          = 1'b0;
        bus_if.valid_i       = 1'b0;
        bus_if.core_rdata_i  = '0;
        bus_if.core_rvalid_i = '0;
        last_rdata = '0;
        exp_drops  = 0;
        exp_tos    = 0;

        rst_n = 1'b0;
        repeat (3) step();
        check_zero("reset");
        rst_n = 1'b1;
        step();

        txn(16'h1004, 16'h0000, 1'b0, 3,      0, 1'b0, 16'hA5A5, "rd_core1");
        txn(16'h2010, 16'h1234, 1'b1, 1,      0, 1'b1, 16'h0000, "wr_core2_b2b");
        txn(16'h0000, 16'h0000, 1'b0, 1000,   0, 1'b0, 16'h0000, "rd_timeout");
        txn(16'h3000, 16'h0000, 1'b0, 1,      0, 1'b1, 16'h0000, "rd_unmapped");
        txn(16'h3000, 16'h5555, 1'b1, 1,      0, 1'b0, 16'h0000, "wr_unmapped");
        txn(16'h0040, 16'h0000, 1'b0, 4,      2, 1'b0, 16'h0BAD, "rd_drop_busy");
        txn(16'h1ABC, 16'h0000, 1'b0, TO + 1, 0, 1'b1, 16'h7E57, "rd_rvalid_at_zero");
        txn(16'h2000, 16'h0000, 1'b0, TO + 2, 0, 1'b0, 16'h1111, "rd_rvalid_late");
        txn(16'h0FFF, 16'h0000, 1'b0, 1,      1, 1'b1, 16'h0F0F, "rd_immediate");
        txn(16'hF123, 16'h9999, 1'b0, 1,      1, 1'b0, 16'h0000, "rd_unmapped_high");

`ifdef CORE_BUS_ROUTER_STATS_EN
        chk("stats.drops_directed",    32'(drop_count),    32'(exp_drops));
        chk("stats.timeouts_directed", 32'(timeout_count), 32'(exp_tos));
`endif

        for (int i = 0; i < 60; i++) begin
            idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(NC, 15))
                                              : int'($urandom_range(0, NC - 1));
            a = {4'(idx), 12'($urandom)};
            txn(a, 16'($urandom), 1'($urandom), int'($urandom_range(1, TO + 4)),
                ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, TO + 3)) : 0,
                1'($urandom), 16'($urandom), $sformatf("rand%0d", i));
        end

`ifdef CORE_BUS_ROUTER_STATS_EN
        chk("stats.drops_random",    32'(drop_count),    32'(exp_drops));
        chk("stats.timeouts_random", 32'(timeout_count), 32'(exp_tos));
`endif

        // Reset while waiting on core 1; its late rvalid must not produce a response.
        bus_if.addr_i  = 16'h1004;
        bus_if.wdata_i = 16'h0000;
        bus_if.rw_i    = 1'b0;
        bus_if.valid_i = 1'b1;
        step();
        bus_if.valid_i = 1'b0;
        step();
        step();
        chk("midrst.busy_before", 32'(bus_if.busy_o), 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_zero("midrst");
        bus_if.core_rdata_i[31:16] = 16'hBEEF;
        bus_if.core_rvalid_i       = 3'b010;
        step();
        bus_if.core_rvalid_i = '0;
        n_val = 0; n_busy = 0; n_strb = 0;
        for (int n = 0; n < 6; n++) begin
            if (bus_if.valid_o) n_val++;
            if (bus_if.busy_o) n_busy++;
            if (bus_if.core_valid_o != '0) n_strb++;
            step();
        end
        chk("midrst.late_resp",   32'(n_val),  32'd0);
        chk("midrst.busy_after",  32'(n_busy), 32'd0);
        chk("midrst.strobes",     32'(n_strb), 32'd0);
        chk("midrst.rdata_clear", 32'(bus_if.rdata_o), 32'd0);
        last_rdata = '0;
        exp_drops  = 0;
        exp_tos    = 0;
`ifdef CORE_BUS_ROUTER_STATS_EN
        chk("midrst.drops_clear",    32'(drop_count),    32'd0);
        chk("midrst.timeouts_clear", 32'(timeout_count), 32'd0);
`endif
        txn(16'h1004, 16'h0000, 1'b0, 2, 0, 1'b0, 16'hC0DE, "rd_after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
